// File: rtl/decimator_10x_pkg.sv
// Shared constants, FSM encoding and the default 20-tap Q1.9 lowpass ROM for decimator_10x.
package decimator_10x_pkg;

    localparam int SAMPLE_W     = 8;
    localparam int COEF_W       = 10;
    localparam int BUF_DEPTH    = 32;
    localparam int BUF_AW       = 5;
    localparam int ACC_W        = SAMPLE_W + COEF_W + 5;
    localparam int DEFAULT_TAPS = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } state_e;

    // Symmetric lowpass, cutoff fs/20, taps sum to exactly 512 (unity DC gain at SHIFT=9).
    // Taps beyond the default length read as zero so TAPS up to 22 stays legal.
    function automatic logic signed [COEF_W-1:0] coef_rom(input logic [BUF_AW-1:0] k);
        logic signed [COEF_W-1:0] h;
        case (k)
            5'd0,  5'd19: h = 10'sd1;
            5'd1,  5'd18: h = 10'sd3;
            5'd2,  5'd17: h = 10'sd7;
            5'd3,  5'd16: h = 10'sd13;
            5'd4,  5'd15: h = 10'sd21;
            5'd5,  5'd14: h = 10'sd30;
            5'd6,  5'd13: h = 10'sd38;
            5'd7,  5'd12: h = 10'sd44;
            5'd8,  5'd11: h = 10'sd49;
            5'd9,  5'd10: h = 10'sd50;
            default:      h = 10'sd0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/decimator_10x_ring.sv
// 32x8 sample ring: register storage, wrapping write pointer, asynchronous read port.
// One write per wr_vld cycle; reads are combinational and never stall.
module sample_ring_32x8
    import decimator_10x_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_vld,
    input  logic [SAMPLE_W-1:0] wr_dat,
    input  logic [BUF_AW-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_dat,
    output logic [BUF_AW-1:0]   wp
);

    logic [SAMPLE_W-1:0] mem_q [BUF_DEPTH];
    logic [SAMPLE_W-1:0] mem_d [BUF_DEPTH];
    logic [BUF_AW-1:0]   wp_q;
    logic [BUF_AW-1:0]   wp_d;

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        if (wr_vld) begin
            mem_d[wp_q] = wr_dat;
            wp_d        = wp_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wp_q  <= wp_d;
            mem_q <= mem_d;
        end
    end

    assign rd_dat = mem_q[rd_addr];
    assign wp     = wp_q;

endmodule

// File: rtl/decimator_10x.sv
// 10x FIR decimator: one TAPS-cycle MAC pass per clk_en over the newest TAPS samples, then round/saturate.
// Latency clk_en->sample_valid is TAPS+2 cycles; no backpressure, a clk_en during a pass is dropped and sets overrun.
module decimator_10x
    import decimator_10x_pkg::*;
#(
    parameter int TAPS  = DEFAULT_TAPS,
    parameter int SHIFT = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic                       clk_en_10x,
    input  logic signed [SAMPLE_W-1:0] sample_x0,
    output logic signed [SAMPLE_W-1:0] sample_y0,
    output logic                       sample_valid,
    output logic                       overrun
);

    localparam int PROD_W = SAMPLE_W + COEF_W;
    localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W + 1)'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W:0] Y_MAX    = (ACC_W + 1)'(127);
    localparam logic signed [ACC_W:0] Y_MIN    = (ACC_W + 1)'(-128);

    state_e                     state_q, state_d;
    logic [BUF_AW-1:0]          base_q, base_d;
    logic [BUF_AW-1:0]          k_q, k_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] y_q, y_d;
    logic                       vld_q, vld_d;
    logic                       ovr_q, ovr_d;

    logic [BUF_AW-1:0]          rd_addr;
    logic [SAMPLE_W-1:0]        rd_dat;
    logic [BUF_AW-1:0]          wp;
    logic signed [SAMPLE_W-1:0] rd_s;
    logic signed [COEF_W-1:0]   coef;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W:0]      rnd;
    logic signed [ACC_W:0]      shf;
    logic signed [SAMPLE_W-1:0] sat_y;

    sample_ring_32x8 u_ring (
        .clk     (clk),
        .rst     (reset),
        .wr_vld  (clk_en_10x),
        .wr_dat  (sample_x0),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat),
        .wp      (wp)
    );

    // Tap k reads k samples back from the newest one; 5-bit subtraction wraps the ring.
    assign rd_addr = base_q - k_q;
    assign rd_s    = rd_dat;
    assign coef    = coef_rom(k_q);

    always_comb begin
        prod  = PROD_W'(rd_s) * PROD_W'(coef);
        rnd   = (ACC_W + 1)'(acc_q) + RND_BIAS;
        shf   = rnd >>> SHIFT;
        sat_y = shf[SAMPLE_W-1:0];
        if (shf > Y_MAX) begin
            sat_y = 8'sh7F;
        end else if (shf < Y_MIN) begin
            sat_y = 8'sh80;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        acc_d   = acc_q;
        y_d     = y_q;
        vld_d   = 1'b0;
        ovr_d   = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (clk_en) begin
                    state_d = ST_MAC;
                    // Without a same-cycle write the newest sample sits one slot behind wp.
                    base_d  = clk_en_10x ? wp : wp - 5'd1;
                    acc_d   = '0;
                    k_d     = '0;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + 5'd1;
                if (k_q == BUF_AW'(TAPS - 1)) begin
                    state_d = ST_ROUND;
                end
                if (clk_en) begin
                    ovr_d = 1'b1;
                end
            end
            ST_ROUND: begin
                y_d     = sat_y;
                vld_d   = 1'b1;
                state_d = ST_IDLE;
                if (clk_en) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sample_y0    = y_q;
    assign sample_valid = vld_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_decimator_10x.sv
// Randomized and directed bench for decimator_10x (SHIFT=9 and SHIFT=8 instances) against a history-based model.
module tb_decimator_10x;

    localparam int TAPS = 20;
    localparam int H [0:19] = '{1, 3, 7, 13, 21, 30, 38, 44, 49, 50,
                                50, 49, 44, 38, 30, 21, 13, 7, 3, 1};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clk_en = 1'b0;
    logic              clk_en_10x = 1'b0;
    logic signed [7:0] xin = '0;
    logic signed [7:0] y9, y8;
    logic              v9, v8, o9, o8;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Reference model state
    int hist[$];
    int ecount = 0;
    bit pend = 1'b0;
    int pend_edge = 0;
    int pend_y9 = 0, pend_y8 = 0;
    int m_y9 = 0, m_y8 = 0, m_vld = 0, m_ovr = 0;

    int cap9[$];
    int cap8[$];
    int vld_edges[$];
    int t_edge;

    decimator_10x #(.TAPS(TAPS), .SHIFT(9)) dut9 (
        .clk(clk), .reset(rst), .clk_en(clk_en), .clk_en_10x(clk_en_10x),
        .sample_x0(xin), .sample_y0(y9), .sample_valid(v9), .overrun(o9)
    );

    decimator_10x #(.TAPS(TAPS), .SHIFT(8)) dut8 (
        .clk(clk), .reset(rst), .clk_en(clk_en), .clk_en_10x(clk_en_10x),
        .sample_x0(xin), .sample_y0(y8), .sample_valid(v8), .overrun(o8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIR over the newest TAPS samples written since reset (older history is zero).
    function automatic int model_out(input int shift);
        int acc = 0;
        int n = hist.size() - 1;
        int r;
        for (int k = 0; k < TAPS; k++) begin
            if (n - k >= 0) acc += hist[n - k] * H[k];
        end
        r = (acc + (1 << (shift - 1))) >>> shift;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic int cap_at(input int i);
        return (i < cap9.size()) ? cap9[i] : -999;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            pend  = 1'b0;
            m_y9  = 0;
            m_y8  = 0;
            m_vld = 0;
            m_ovr = 0;
        end else begin
            ecount++;
            m_vld = 0;
            if (clk_en_10x) hist.push_back(int'(xin));
            if (clk_en) begin
                if (pend) begin
                    m_ovr = 1;
                end else begin
                    pend      = 1'b1;
                    pend_edge = ecount + TAPS + 1;
                    pend_y9   = model_out(9);
                    pend_y8   = model_out(8);
                end
            end
            if (pend && ecount == pend_edge) begin
                m_vld = 1;
                m_y9  = pend_y9;
                m_y8  = pend_y8;
                pend  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("y0_shift9", int'(y9), m_y9);
            chk("y0_shift8", int'(y8), m_y8);
            chk("valid_shift9", int'(v9), m_vld);
            chk("valid_shift8", int'(v8), m_vld);
            chk("overrun_shift9", int'(o9), m_ovr);
            chk("overrun_shift8", int'(o8), m_ovr);
            if (v9) begin
                cap9.push_back(int'(y9));
                cap8.push_back(int'(y8));
                vld_edges.push_back(ecount);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cap9.delete();
        cap8.delete();
        vld_edges.delete();
    endtask

    task automatic drive_sample(input logic [7:0] x, input bit with_ce);
        clk_en_10x = 1'b1;
        clk_en     = with_ce;
        xin        = x;
        tick();
        clk_en_10x = 1'b0;
        clk_en     = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2;
        rst = 1'b1;
        chk_on = 1'b1;
        tick();
        tick();
        chk("reset_y0", int'(y9), 0);
        chk("reset_valid", int'(v9), 0);
        chk("reset_overrun", int'(o9), 0);
        rst = 1'b0;

        // DC 0x10
        do_reset();
        for (int i = 0; i < 40; i++) drive_sample(8'h10, (i % 10) == 0);
        repeat (30) tick();
        chk("dc_count", cap9.size(), 4);
        chk("dc_first_partial", cap_at(0), 0);
        chk("dc_third", cap_at(2), 16);
        chk("dc_fourth", cap_at(3), 16);
        chk("dc_hold", int'(y9), 16);

        // Impulse 0x7F
        do_reset();
        for (int i = 0; i < 30; i++) drive_sample((i == 0) ? 8'h7F : 8'h00, (i % 10) == 0);
        repeat (30) tick();
        chk("imp_count", cap9.size(), 3);
        chk("imp_h0", cap_at(0), 0);
        chk("imp_h10", cap_at(1), 12);
        chk("imp_tail", cap_at(2), 0);

        // Saturation at SHIFT=8
        do_reset();
        for (int i = 0; i < 30; i++) drive_sample(8'h50, (i % 10) == 0);
        repeat (30) tick();
        chk("sat_pos_shift8", int'(y8), 127);
        chk("sat_pos_shift9", int'(y9), 80);
        for (int i = 0; i < 30; i++) drive_sample(8'hB0, (i % 10) == 0);
        repeat (30) tick();
        chk("sat_neg_shift8", int'(y8), -128);
        chk("sat_neg_shift9", int'(y9), -80);

        // Overrun and latency
        do_reset();
        clk_en = 1'b1; clk_en_10x = 1'b1; xin = 8'sh20;
        tick();
        t_edge = ecount;
        clk_en = 1'b0; clk_en_10x = 1'b0;
        repeat (4) tick();
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        repeat (40) tick();
        chk("ovr_flag", int'(o9), 1);
        chk("ovr_one_valid", cap9.size(), 1);
        chk("latency", (vld_edges.size() > 0) ? vld_edges[0] - t_edge + 1 : -1, 22);
        chk("ovr_sticky", int'(o8), 1);

        // Reset in the middle of MAC
        do_reset();
        clk_en = 1'b1; clk_en_10x = 1'b1; xin = 8'sh10;
        tick();
        clk_en = 1'b0; clk_en_10x = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("midreset_no_valid", cap9.size(), 0);
        chk("midreset_y0", int'(y9), 0);
        chk("midreset_overrun", int'(o9), 0);
        for (int i = 0; i < 5; i++) drive_sample(8'h10, i == 4);
        repeat (30) tick();
        chk("zero_hist_shift9", cap_at(0), 1);
        chk("zero_hist_shift8", (cap8.size() > 0) ? cap8[0] : -999, 3);

        // Randomized traffic with variable input spacing and stray clk_en strobes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int gap;
            gap        = $urandom_range(2, 4);
            clk_en_10x = 1'b1;
            clk_en     = ((i % 10) == 0) || ($urandom_range(0, 49) == 0);
            xin        = 8'($urandom);
            tick();
            clk_en_10x = 1'b0;
            for (int g = 1; g < gap; g++) begin
                clk_en = ($urandom_range(0, 59) == 0);
                tick();
            end
            clk_en = 1'b0;
        end
        repeat (30) tick();
        chk("rand_outputs_seen", int'(cap9.size() >= 25), 1);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
